// File: rtl/neuroset_pkg.sv
// Shared definitions for the neuroset convolution path: matrix limits,
// column/row border codes and the raster-scan state encoding.
package neuroset_pkg;

  localparam int MAX_MATRIX = 28;
  localparam int IDX_W      = 10;
  localparam int DIM_W      = 5;

  // Border codes shared by the column (prov) and row (vprov) flags.
  localparam logic [1:0] PROV_INT   = 2'b00;
  localparam logic [1:0] PROV_RIGHT = 2'b10;
  localparam logic [1:0] PROV_LEFT  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // First edge wins over last edge, so a 1-wide map always reports "first".
  function automatic logic [1:0] edge_code(input logic is_first, input logic is_last);
    if (is_first) begin
      return PROV_LEFT;
    end else if (is_last) begin
      return PROV_RIGHT;
    end
    return PROV_INT;
  endfunction

endpackage

// File: rtl/border_scan_cnt.sv
// Row/column/flat-index counter for the raster scan. Steps col, wraps to the
// next row at m-1, and registers the last-beat flag. The next-state edge
// flags are exported so the top can register border codes alongside i.
// Optional macro BORDER_SCAN_ROWFLAG_EN adds the next-row edge flags.
module border_scan_cnt #(
  parameter int IDX_W = neuroset_pkg::IDX_W,
  parameter int DIM_W = neuroset_pkg::DIM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic             clear,
  input  logic [DIM_W-1:0] m,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic [IDX_W-1:0] i,
  output logic             last,
  output logic             nxt_first_col,
  output logic             nxt_last_col
`ifdef BORDER_SCAN_ROWFLAG_EN
  ,
  output logic             nxt_first_row,
  output logic             nxt_last_row
`endif
);

  logic [DIM_W-1:0] m_last;
  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic             last_q, last_d;

  assign m_last = m - DIM_W'(1);

  // Next-count computation: clear beats load beats advance; otherwise hold.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    row_d  = row_q;
    col_d  = col_q;
    i_d    = i_q;
    last_d = last_q;
    if (clear) begin
      row_d  = '0;
      col_d  = '0;
      i_d    = '0;
      last_d = 1'b0;
    end else if (load) begin
      row_d  = '0;
      col_d  = '0;
      i_d    = '0;
      last_d = (m_last == '0);
    end else if (advance) begin
      if (col_q == m_last) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
      i_d    = i_q + IDX_W'(1);
      last_d = (row_d == m_last) && (col_d == m_last);
    end
  end

  assign nxt_first_col = (col_d == '0);
  assign nxt_last_col  = (col_d == m_last);
`ifdef BORDER_SCAN_ROWFLAG_EN
  assign nxt_first_row = (row_d == '0);
  assign nxt_last_row  = (row_d == m_last);
`endif

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      i_q    <= '0;
      last_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      row_q  <= row_d;
      col_q  <= col_d;
      i_q    <= i_d;
      last_q <= last_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign i    = i_q;
  assign last = last_q;

endmodule

// File: rtl/border_scan_gen.sv
// Raster-scan index producer: after an accepted start it walks a
// matrix x matrix map, one valid/ready beat per index, emitting i, row, col,
// last and the column-border code prov. Out-of-range starts pulse err.
// Optional macro BORDER_SCAN_ROWFLAG_EN adds the row-border output vprov.
module border_scan_gen #(
  parameter int MAX_MATRIX = neuroset_pkg::MAX_MATRIX,
  parameter int IDX_W      = neuroset_pkg::IDX_W,
  parameter int DIM_W      = neuroset_pkg::DIM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] matrix,
  input  logic             ready,
  output logic             valid,
  output logic [IDX_W-1:0] i,
  output logic [1:0]       prov,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef BORDER_SCAN_ROWFLAG_EN
  ,
  output logic [1:0]       vprov
`endif
);

  import neuroset_pkg::*;

  scan_state_e      state_q, state_d;
  logic [DIM_W-1:0] m_q, m_d;
  logic [DIM_W-1:0] cnt_m;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       prov_q, prov_d;
  logic             cnt_load, cnt_adv, cnt_clr;
  logic             start_ok, xfer;
  logic             nxt_first_col, nxt_last_col;
`ifdef BORDER_SCAN_ROWFLAG_EN
  logic [1:0]       vprov_q, vprov_d;
  logic             nxt_first_row, nxt_last_row;
`endif

  assign start_ok = (matrix != '0) && (matrix <= DIM_W'(MAX_MATRIX));
  assign xfer     = valid_q && ready;
  // On the load cycle the side length is not latched yet, so feed it through.
  assign cnt_m    = cnt_load ? matrix : m_q;

  border_scan_cnt #(
    .IDX_W (IDX_W),
    .DIM_W (DIM_W)
  ) u_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (cnt_load),
    .advance       (cnt_adv),
    .clear         (cnt_clr),
    .m             (cnt_m),
    .row           (row),
    .col           (col),
    .i             (i),
    .last          (last),
    .nxt_first_col (nxt_first_col),
    .nxt_last_col  (nxt_last_col)
`ifdef BORDER_SCAN_ROWFLAG_EN
    ,
    .nxt_first_row (nxt_first_row),
    .nxt_last_row  (nxt_last_row)
`endif
  );

  // FSM next state, handshake and border-code next values.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    prov_d   = prov_q;
    cnt_load = 1'b0;
    cnt_adv  = 1'b0;
    cnt_clr  = 1'b0;
`ifdef BORDER_SCAN_ROWFLAG_EN
    vprov_d  = vprov_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            m_d      = matrix;
            cnt_load = 1'b1;
            valid_d  = 1'b1;
            state_d  = SCAN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (xfer) begin
          if (last) begin
            cnt_clr = 1'b1;
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_adv = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Border codes follow the counter's next position so they line up with i.
    if (cnt_clr) begin
      prov_d = PROV_INT;
`ifdef BORDER_SCAN_ROWFLAG_EN
      vprov_d = PROV_INT;
`endif
    end else if (cnt_load || cnt_adv) begin
      prov_d = edge_code(nxt_first_col, nxt_last_col);
`ifdef BORDER_SCAN_ROWFLAG_EN
      vprov_d = edge_code(nxt_first_row, nxt_last_row);
`endif
    end
    busy_d = (state_d == SCAN);
  end

  // State, handshake and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      prov_q  <= PROV_INT;
`ifdef BORDER_SCAN_ROWFLAG_EN
      vprov_q <= PROV_INT;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      prov_q  <= prov_d;
`ifdef BORDER_SCAN_ROWFLAG_EN
      vprov_q <= vprov_d;
`endif
    end
  end

  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign prov  = prov_q;
`ifdef BORDER_SCAN_ROWFLAG_EN
  assign vprov = vprov_q;
`endif

endmodule
